sram_arbiter: RTL and testbench

- Shares the single external 16-bit asynchronous SRAM (19-bit address) between two requesters: the instruction-fetch port (read-only) and the data load/store port of the control FSM.
- Arbitrates between them and sequences each SRAM cycle with a programmable number of wait states.
- Sits between control_fsm and the SRAM pins. It is the only block that drives sram_addr_full, sram_we_n, sram_oe_n, sram_ce_n and the data-bus output enable.

---
 rtl/sram_arbiter_if.sv | 39 +++
 rtl/sram_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester and SRAM pin bundle for sram_arbiter
interface sram_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 16
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic [ADDR_W-1:0] sram_addr_full;
   logic [DATA_W-1:0] sram_dq_out;
   logic              sram_dq_oe;
   logic [DATA_W-1:0] sram_dq_in;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic              busy;

   // master: requesters plus the SRAM data pins feeding back in
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_dq_in,
      input  i_ack, i_rdata, d_ack, d_rdata, sram_addr_full, sram_dq_out,
             sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, busy
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_dq_in,
      output i_ack, i_rdata, d_ack, d_rdata, sram_addr_full, sram_dq_out,
             sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, busy
   );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and wait-state sequencer for an async SRAM
// SRAM_ARB_FIXED_PRIO_EN selects fixed data-first priority instead of round-robin.
module sram_arbiter #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 16,
   parameter int WAIT_CYC = 2
) (
   input logic           clk,
   input logic           rst,
   sram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
   localparam logic       ZERO_WAIT = 1'(WAIT_CYC == 0);

   state_t            state;
   logic [3:0]        cnt;
   logic              gnt_d;
   logic              wr;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] dq_out_q;
   logic              dq_oe_q;
   logic              ce_n_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic              i_ack_q;
   logic              d_ack_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              busy_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
   logic              rr_last_d;
`endif

   logic grant_d;
   logic start_wr;

   always_comb begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      grant_d = bus.d_req;
`else
      // On a tie the port that was not served last wins.
      grant_d = bus.d_req && !(bus.i_req && rr_last_d);
`endif
      start_wr = grant_d && bus.d_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         gnt_d     <= 1'b0;
         wr        <= 1'b0;
         addr_q    <= '0;
         dq_out_q  <= '0;
         dq_oe_q   <= 1'b0;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         busy_q    <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         rr_last_d <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               if (bus.i_req || bus.d_req) begin
                  state  <= ACCESS;
                  cnt    <= WAIT_INIT;
                  gnt_d  <= grant_d;
                  wr     <= start_wr;
                  addr_q <= grant_d ? bus.d_addr : bus.i_addr;
                  if (grant_d) dq_out_q <= bus.d_wdata;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                  rr_last_d <= grant_d;
`endif
                  busy_q  <= 1'b1;
                  ce_n_q  <= 1'b0;
                  oe_n_q  <= start_wr;
                  we_n_q  <= !start_wr;
                  dq_oe_q <= start_wr;
               end else begin
                  busy_q  <= 1'b0;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
                  dq_oe_q <= 1'b0;
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  state  <= DONE;
                  ce_n_q <= 1'b1;
                  oe_n_q <= 1'b1;
                  we_n_q <= 1'b1;
                  // With no wait states the bus is held one more cycle after we_n rises.
                  dq_oe_q <= ZERO_WAIT && wr;
                  if (!wr) begin
                     if (gnt_d) d_rdata_q <= bus.sram_dq_in;
                     else       i_rdata_q <= bus.sram_dq_in;
                  end
                  if (gnt_d) d_ack_q <= 1'b1;
                  else       i_ack_q <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
                  // Raise we_n for the final access cycle so address/data are held past it.
                  if (wr && cnt == 4'd1) we_n_q <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               dq_oe_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.i_ack          = i_ack_q;
   assign bus.i_rdata        = i_rdata_q;
   assign bus.d_ack          = d_ack_q;
   assign bus.d_rdata        = d_rdata_q;
   assign bus.sram_addr_full = addr_q;
   assign bus.sram_dq_out    = dq_out_q;
   assign bus.sram_dq_oe     = dq_oe_q;
   assign bus.sram_ce_n      = ce_n_q;
   assign bus.sram_oe_n      = oe_n_q;
   assign bus.sram_we_n      = we_n_q;
   assign bus.busy           = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector bench for sram_arbiter at WAIT_CYC 2 and 0
module tb_sram_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_arbiter_if #(.ADDR_W(19), .DATA_W(16)) b2 ();
   sram_arbiter_if #(.ADDR_W(19), .DATA_W(16)) b0 ();

   sram_arbiter #(.ADDR_W(19), .DATA_W(16), .WAIT_CYC(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   sram_arbiter #(.ADDR_W(19), .DATA_W(16), .WAIT_CYC(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          sel;      // 1 = WAIT_CYC 2 instance, 0 = WAIT_CYC 0 instance
      bit          dport;
      bit          we;
      bit          drop;
      logic [18:0] addr;
      logic [15:0] wdata;
      logic [15:0] dq;
      int          ack_cyc;
      logic [5:0]  ce_n, oe_n, we_n, dq_oe, ack, busy;   // bit c = cycle c
   } vec_t;

   vec_t tv[8];
   logic [15:0] exp_ird[2];
   logic [15:0] exp_drd[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic ir, input logic dr, input logic we,
                        input logic [18:0] a, input logic [15:0] wd, input logic [15:0] dq);
      if (sel) begin
         b2.i_req = ir; b2.d_req = dr; b2.d_we = we; b2.i_addr = a; b2.d_addr = a;
         b2.d_wdata = wd; b2.sram_dq_in = dq;
      end else begin
         b0.i_req = ir; b0.d_req = dr; b0.d_we = we; b0.i_addr = a; b0.d_addr = a;
         b0.d_wdata = wd; b0.sram_dq_in = dq;
      end
   endtask

   // {ce_n, oe_n, we_n, dq_oe, i_ack, d_ack, busy}
   function automatic logic [6:0] strobes(input bit sel);
      if (sel) return {b2.sram_ce_n, b2.sram_oe_n, b2.sram_we_n, b2.sram_dq_oe, b2.i_ack, b2.d_ack, b2.busy};
      return {b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n, b0.sram_dq_oe, b0.i_ack, b0.d_ack, b0.busy};
   endfunction

   function automatic logic [18:0] addr_of(input bit sel);
      return sel ? b2.sram_addr_full : b0.sram_addr_full;
   endfunction

   function automatic logic [15:0] dqo_of(input bit sel);
      return sel ? b2.sram_dq_out : b0.sram_dq_out;
   endfunction

   function automatic logic [15:0] ird_of(input bit sel);
      return sel ? b2.i_rdata : b0.i_rdata;
   endfunction

   function automatic logic [15:0] drd_of(input bit sel);
      return sel ? b2.d_rdata : b0.d_rdata;
   endfunction

   initial begin
      vec_t v;
      logic [6:0] e;
      logic exp_i, exp_d;
      bit rd;
      int acks;

      //        sel dp we dr addr       wdata     dq        ack  ce_n       oe_n       we_n       dq_oe      ack        busy
      tv[0] = '{1, 0, 0, 0, 19'h00123, 16'h0000, 16'hBEEF, 4, 6'b110001, 6'b110001, 6'b111111, 6'b000000, 6'b010000, 6'b011110};
      tv[1] = '{1, 1, 1, 0, 19'h7FFFF, 16'h1234, 16'hDEAD, 4, 6'b110001, 6'b111111, 6'b111001, 6'b001110, 6'b010000, 6'b011110};
      tv[2] = '{1, 1, 0, 0, 19'h00ABC, 16'h0000, 16'hCAFE, 4, 6'b110001, 6'b110001, 6'b111111, 6'b000000, 6'b010000, 6'b011110};
      tv[3] = '{1, 0, 1, 0, 19'h40000, 16'h9999, 16'h0001, 4, 6'b110001, 6'b110001, 6'b111111, 6'b000000, 6'b010000, 6'b011110};
      tv[4] = '{0, 0, 0, 0, 19'h00005, 16'h0000, 16'h5A5A, 2, 6'b111101, 6'b111101, 6'b111111, 6'b000000, 6'b000100, 6'b000110};
      tv[5] = '{0, 1, 1, 0, 19'h12345, 16'hA5A5, 16'hDEAD, 2, 6'b111101, 6'b111111, 6'b111101, 6'b000110, 6'b000100, 6'b000110};
      tv[6] = '{0, 0, 0, 1, 19'h00777, 16'h0000, 16'h0F0F, 2, 6'b111101, 6'b111101, 6'b111111, 6'b000000, 6'b000100, 6'b000110};
      tv[7] = '{0, 1, 0, 0, 19'h3FFFF, 16'h0000, 16'hFFFF, 2, 6'b111101, 6'b111101, 6'b111111, 6'b000000, 6'b000100, 6'b000110};
      exp_ird = '{16'h0, 16'h0};
      exp_drd = '{16'h0, 16'h0};

      rst = 1'b1;
      drive(1, 0, 0, 0, '0, '0, '0);
      drive(0, 0, 0, 0, '0, '0, '0);
      repeat (3) tick();
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("reset dut%0d strobes", s), strobes(s[0]), 7'b1110000);
         chk($sformatf("reset dut%0d addr", s), addr_of(s[0]), 19'h0);
         chk($sformatf("reset dut%0d dq_out", s), dqo_of(s[0]), 16'h0);
         chk($sformatf("reset dut%0d rdata", s), {ird_of(s[0]), drd_of(s[0])}, 32'h0);
      end
      rst = 1'b0;
      tick();

      for (int k = 0; k < 8; k++) begin
         v = tv[k];
         rd = !v.dport || !v.we;
         drive(v.sel, !v.dport, v.dport, v.we, v.addr, v.wdata, v.dq);
         for (int c = 0; c < 6; c++) begin
            e = {v.ce_n[c], v.oe_n[c], v.we_n[c], v.dq_oe[c],
                 v.dport ? 1'b0 : v.ack[c], v.dport ? v.ack[c] : 1'b0, v.busy[c]};
            chk($sformatf("vec%0d cyc%0d strobes", k, c), strobes(v.sel), e);
            if (c == v.ack_cyc - 1) begin
               chk($sformatf("vec%0d addr", k), addr_of(v.sel), v.addr);
               if (!rd) chk($sformatf("vec%0d dq_out", k), dqo_of(v.sel), v.wdata);
            end
            if (c == v.ack_cyc) begin
               if (rd && v.dport)  exp_drd[v.sel] = v.dq;
               if (rd && !v.dport) exp_ird[v.sel] = v.dq;
               chk($sformatf("vec%0d i_rdata", k), ird_of(v.sel), exp_ird[v.sel]);
               chk($sformatf("vec%0d d_rdata", k), drd_of(v.sel), exp_drd[v.sel]);
               drive(v.sel, 0, 0, 0, v.addr, v.wdata, v.dq);
            end
            // Requester inputs change mid-transfer; the latched values must win.
            if (c == 1)
               drive(v.sel, !v.dport && !v.drop, v.dport && !v.drop, !v.we, ~v.addr, ~v.wdata, v.dq);
            tick();
         end
      end

      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      drive(1, 1, 1, 0, 19'h00042, 16'h0, 16'h4242);
      for (int c = 0; c < 25; c++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         exp_d = (c == 4 || c == 9 || c == 14 || c == 19);
         exp_i = (c == 24);
`else
         exp_d = (c == 4 || c == 14);
         exp_i = (c == 9 || c == 19);
`endif
         chk($sformatf("both cyc%0d {i_ack,d_ack}", c), {b2.i_ack, b2.d_ack}, {exp_i, exp_d});
`ifdef SRAM_ARB_FIXED_PRIO_EN
         if (c == 19) drive(1, 1, 0, 0, 19'h00042, 16'h0, 16'h4242);
`else
         if (c == 19) drive(1, 0, 0, 0, 19'h00042, 16'h0, 16'h4242);
`endif
         if (c == 24) drive(1, 0, 0, 0, 19'h00042, 16'h0, 16'h4242);
         tick();
      end
      repeat (2) tick();

      drive(1, 0, 1, 1, 19'h00100, 16'h5555, 16'h0);
      tick();
      tick();
      chk("rst-write we_n before reset", b2.sram_we_n, 1'b0);
      rst = 1'b1;
      drive(1, 0, 0, 0, 19'h00100, 16'h5555, 16'h0);
      tick();
      rst = 1'b0;
      chk("rst-write {we_n,dq_oe,busy,d_ack}", {b2.sram_we_n, b2.sram_dq_oe, b2.busy, b2.d_ack}, 4'b1000);
      acks = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         acks += int'(b2.d_ack);
      end
      chk("rst-write stray d_ack count", acks, 0);
      drive(1, 0, 1, 1, 19'h00100, 16'h6666, 16'h0);
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("reissue cyc%0d d_ack", c), b2.d_ack, 1'(c == 4));
         if (c == 3) chk("reissue dq_out", b2.sram_dq_out, 16'h6666);
         if (c == 4) drive(1, 0, 0, 0, 19'h00100, 16'h6666, 16'h0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
